uart_tx_responder: RTL and testbench



---
 rtl/uart_tx_pkg.sv | 43 ++++
 rtl/uart_tx_fifo.sv | 56 +++++
 rtl/uart_tx_responder.sv | 273 +++++++++++++++++++++++++++
 tb/tb_uart_tx_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit responder:
// register map, status bit positions, reset values and shifter states.
package uart_tx_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] A_RBR_THR = 3'd0;
    localparam logic [2:0] A_IER     = 3'd1;
    localparam logic [2:0] A_IIR_FCR = 3'd2;
    localparam logic [2:0] A_LCR     = 3'd3;
    localparam logic [2:0] A_MCR     = 3'd4;
    localparam logic [2:0] A_LSR     = 3'd5;
    localparam logic [2:0] A_MSR     = 3'd6;
    localparam logic [2:0] A_SCR     = 3'd7;
    localparam logic [2:0] A_DLL     = 3'd0;
    localparam logic [2:0] A_DLM     = 3'd1;

    localparam int LSR_TEMT  = 6;
    localparam int LSR_THRE  = 5;
    localparam int IER_ETBEI = 1;
    localparam int FCR_EN    = 0;
    localparam int FCR_TXCLR = 2;
    localparam int LCR_DLAB  = 7;
    localparam int LCR_BRK   = 6;
    localparam int LCR_STB   = 2;

    localparam logic [7:0] LCR_RST = 8'h00;
    localparam logic [7:0] DL_RST  = 8'h00;
    localparam logic [7:0] REG_RST = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    // Index of the last data bit for the LCR word-length field.
    function automatic logic [2:0] last_data_idx(input logic [1:0] wls);
        return {1'b0, wls} + 3'd4;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the transmit path.
// Ports: clk/rst, push/pop/clear, wdata/rdata, full/empty/count.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW:0]       cnt;
    logic              do_push;
    logic              do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign count   = cnt;
    assign rdata   = mem[rptr];
    // A pop in the same cycle frees the slot a full push needs.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_responder.sv
// 16750-style UART register responder, transmit side only.
// Ports: clk, rst, baudce, bus cs/wr/rd/a/din/dout, intr (THRE), sout.
module uart_tx_responder
    import uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baudce,
    input  logic       cs,
    input  logic       wr,
    input  logic       rd,
    input  logic [2:0] a,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       intr,
    output logic       sout
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic wr_q;
    logic rd_q;
    logic we;
    logic re;

    logic [7:0] lcr;
    logic [7:0] dll;
    logic [7:0] dlm;
    logic [7:0] mcr;
    logic [7:0] scr;
    logic       ier_etbei;
    logic       fcr_en;
    logic       dlab;

    logic wr_thr;
    logic wr_ier;
    logic ier_rise;
    logic iir_rd;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_clr;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [AW:0]       fifo_cnt;
    logic [AW:0]       eff_depth;

    logic thre_ip;
    logic empty_q;
    logic thre_set;

    logic [15:0] divisor;
    logic [15:0] pcnt;
    logic [3:0]  tcnt;
    logic        div_zero;
    logic        tick;
    logic        bit_end;

    tx_state_e   state;
    tx_state_e   state_nxt;
    logic [2:0]  bcnt;
    logic [7:0]  shreg;
    logic        data_last;
    logic        stop_last;
    logic        line;

    logic [7:0] rdata;
    logic [7:0] lsr;
    logic [7:0] iir;

    // Strobes commit once, on the first cycle they are seen.
    assign we   = cs & wr & ~wr_q;
    assign re   = cs & rd & ~rd_q;
    assign dlab = lcr[LCR_DLAB];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= 1'b0;
            rd_q <= 1'b0;
        end else begin
            wr_q <= cs & wr;
            rd_q <= cs & rd;
        end
    end

    assign wr_thr   = we & (a == A_RBR_THR) & ~dlab;
    assign wr_ier   = we & (a == A_IER) & ~dlab;
    assign ier_rise = wr_ier & din[IER_ETBEI] & ~ier_etbei;
    assign iir_rd   = re & (a == A_IIR_FCR);
    assign fifo_clr = we & (a == A_IIR_FCR) & din[FCR_TXCLR];

    always_ff @(posedge clk) begin
        if (rst) begin
            lcr       <= LCR_RST;
            dll       <= DL_RST;
            dlm       <= DL_RST;
            mcr       <= REG_RST;
            scr       <= REG_RST;
            ier_etbei <= 1'b0;
            fcr_en    <= 1'b0;
        end else if (we) begin
            case (a)
                A_RBR_THR: if (dlab) dll <= din;
                A_IER: begin
                    if (dlab) dlm <= din;
                    else      ier_etbei <= din[IER_ETBEI];
                end
                A_IIR_FCR: fcr_en <= din[FCR_EN];
                A_LCR:     lcr <= din;
                A_MCR:     mcr <= din;
                A_SCR:     scr <= din;
                default:   ;
            endcase
        end
    end

    // With the FIFO disabled only one byte may wait behind the shifter.
    assign eff_depth = fcr_en ? (AW+1)'(FIFO_DEPTH) : (AW+1)'(1);
    assign fifo_push = wr_thr &
                       (((fifo_cnt < eff_depth) & ~fifo_full) | fifo_pop);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (fifo_clr),
        .wdata (din),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // An accepted THR write empties nothing, so it overrides a set;
    // a set overrides an IIR-read clear.
    assign thre_set = (fifo_empty & ~empty_q) | (ier_rise & fifo_empty);

    always_ff @(posedge clk) begin
        if (rst) begin
            empty_q <= 1'b1;
            thre_ip <= 1'b0;
        end else begin
            empty_q <= fifo_empty;
            if (fifo_push)     thre_ip <= 1'b0;
            else if (thre_set) thre_ip <= 1'b1;
            else if (iir_rd)   thre_ip <= 1'b0;
        end
    end

    assign intr = ier_etbei & thre_ip;

    // Baud prescaler: one tick every divisor enabled cycles.
    assign divisor  = {dlm, dll};
    assign div_zero = (divisor == 16'd0);
    assign tick     = baudce & ~div_zero & (pcnt >= divisor - 16'd1);
    assign bit_end  = tick & (tcnt == 4'hF);

    always_ff @(posedge clk) begin
        if (rst || fifo_pop) begin
            pcnt <= '0;
            tcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
            tcnt <= tcnt + 4'd1;
        end else if (baudce && !div_zero) begin
            pcnt <= pcnt + 16'd1;
        end
    end

    // >= keeps a mid-frame word-length shrink from stalling.
    assign data_last = (bcnt >= last_data_idx(lcr[1:0]));
    assign stop_last = (bcnt >= {2'b00, lcr[LCR_STB]});

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && data_last) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end && stop_last) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        state_nxt = ST_START;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            bcnt  <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            if (fifo_pop) begin
                shreg <= fifo_rdata;
                bcnt  <= '0;
            end else if (bit_end) begin
                case (state)
                    ST_DATA: begin
                        shreg <= shreg >> 1;
                        bcnt  <= data_last ? 3'd0 : bcnt + 3'd1;
                    end
                    ST_STOP: bcnt <= bcnt + 3'd1;
                    default: bcnt <= '0;
                endcase
            end
        end
    end

    always_comb begin
        line = 1'b1;
        case (state)
            ST_START: line = 1'b0;
            ST_DATA:  line = shreg[0];
            default:  line = 1'b1;
        endcase
    end

    // Break pulls the pin low while the shifter keeps its timing.
    assign sout = line & ~lcr[LCR_BRK];

    always_comb begin
        lsr = 8'h00;
        lsr[LSR_TEMT] = fifo_empty & (state == ST_IDLE);
        lsr[LSR_THRE] = fifo_empty;
    end

    assign iir = {fcr_en, fcr_en, 4'b0000, thre_ip ? 2'b10 : 2'b01};

    always_comb begin
        rdata = 8'h00;
        case (a)
            A_RBR_THR: rdata = dlab ? dll : 8'h00;
            A_IER:     rdata = dlab ? dlm : {6'b0, ier_etbei, 1'b0};
            A_IIR_FCR: rdata = iir;
            A_LCR:     rdata = lcr;
            A_MCR:     rdata = mcr;
            A_LSR:     rdata = lsr;
            A_MSR:     rdata = 8'h00;
            A_SCR:     rdata = scr;
            default:   rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)     dout <= 8'h00;
        else if (cs) dout <= rdata;
    end

endmodule

// File: tb/tb_uart_tx_responder.sv
// Self-checking bench for uart_tx_responder: register map, interrupt,
// FIFO limits and serial waveform against a bit-list reference model.
module tb_uart_tx_responder;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baudce = 1'b1;
    logic       cs = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [2:0] a = 3'd0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       intr;
    logic       sout;

    int nvec = 0;
    int nerr = 0;
    bit cap_en = 1'b0;
    bit rand_bce = 1'b0;
    logic sq[$];
    logic bq[$];

    always #5 clk = ~clk;

    uart_tx_responder #(.FIFO_DEPTH(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .baudce (baudce),
        .cs     (cs),
        .wr     (wr),
        .rd     (rd),
        .a      (a),
        .din    (din),
        .dout   (dout),
        .intr   (intr),
        .sout   (sout)
    );

    // baudce chosen for the coming edge is recorded with the line level.
    always @(negedge clk) begin
        if (rand_bce) baudce = 1'($urandom % 2);
        else          baudce = 1'b1;
        if (cap_en) begin
            sq.push_back(sout);
            bq.push_back(baudce);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_reg(input logic [2:0] ad, input logic [7:0] d,
                          input int len = 1);
        cs = 1'b1; wr = 1'b1; a = ad; din = d;
        cycles(len);
        cs = 1'b0; wr = 1'b0;
        cycles(1);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] ad,
                          input logic [7:0] exp);
        cs = 1'b1; rd = 1'b1; a = ad;
        cycles(1);
        chk(tag, dout, exp);
        cs = 1'b0; rd = 1'b0;
        cycles(1);
    endtask

    task automatic set_cfg(input logic [7:0] lcrv, input logic [7:0] div);
        wr_reg(3'd3, 8'h80 | lcrv);
        wr_reg(3'd0, div);
        wr_reg(3'd1, 8'h00);
        wr_reg(3'd3, lcrv);
    endtask

    // Expected line level: idle before the first start, then the bit list
    // of all accepted bytes, each bit lasting 16*div enabled cycles.
    task automatic check_wave(input string tag, input byte_q_t bx,
                              input int nb, input int ns, input int div,
                              input int f);
        logic bits[$];
        int   h;
        int   idx;
        logic e;
        foreach (bx[k]) begin
            bits.push_back(1'b0);
            for (int i = 0; i < nb; i++) bits.push_back(bx[k][i]);
            repeat (ns) bits.push_back(1'b1);
        end
        h = 0;
        for (int j = 0; j < sq.size(); j++) begin
            e = 1'b1;
            if (j >= f) begin
                idx = h / (16 * div);
                if (idx < bits.size()) e = bits[idx];
                h += int'(bq[j]);
            end
            chk($sformatf("%s_s%0d", tag, j), sq[j], e);
        end
    endtask

    task automatic send_frames(input string tag, input byte_q_t bw,
                               input byte_q_t bx, input int nb,
                               input int ns, input int div,
                               input int len, input int lsr_exp);
        int need;
        int hc;
        int j;
        int cyc;
        sq.delete();
        bq.delete();
        cap_en = 1'b1;
        foreach (bw[k]) wr_reg(3'd0, bw[k], len);
        if (lsr_exp >= 0) rd_chk({tag, "_lsr"}, 3'd5, 8'(lsr_exp));
        need = bx.size() * (1 + nb + ns) * 16 * div + 16 * div;
        hc = 0;
        j = 2;
        cyc = 0;
        while (hc < need && cyc < 20000) begin
            cycles(1);
            cyc++;
            while (j < bq.size()) begin
                hc += int'(bq[j]);
                j++;
            end
        end
        cap_en = 1'b0;
        if (hc < need) chk({tag, "_timeout"}, hc, need);
        check_wave(tag, bx, nb, ns, div, 2);
    endtask

    initial begin
        byte_q_t bw;
        byte_q_t bx;
        logic [1:0] wls;
        logic stb;
        int div;
        int n;
        int got;

        cycles(3);
        rst = 1'b0;
        cycles(1);
        chk("rst_sout", sout, 1'b1);
        chk("rst_int", intr, 1'b0);
        chk("rst_dout", dout, 8'h00);
        rd_chk("rst_lsr", 3'd5, 8'h60);
        rd_chk("rst_iir", 3'd2, 8'h01);

        set_cfg(8'h03, 8'h01);
        rd_chk("lcr_rb", 3'd3, 8'h03);
        bw = {8'h55};
        send_frames("f55", bw, bw, 8, 1, 1, 3, 8'h20);
        rd_chk("f55_lsr_end", 3'd5, 8'h60);

        wr_reg(3'd2, 8'h01);
        for (int it = 0; it < 4; it++) begin
            wls = 2'($urandom % 4);
            stb = 1'($urandom % 2);
            div = 1 + int'($urandom % 3);
            n = 1 + int'($urandom % 3);
            rand_bce = (it % 2) == 1;
            set_cfg({5'b0, stb, wls}, 8'(div));
            bw.delete();
            for (int k = 0; k < n; k++) bw.push_back(8'($urandom));
            send_frames($sformatf("rnd%0d", it), bw, bw, 5 + int'(wls),
                        stb ? 2 : 1, div, 1, -1);
        end
        rand_bce = 1'b0;

        set_cfg(8'h03, 8'h01);
        bw.delete();
        for (int k = 0; k < 18; k++) bw.push_back(8'($urandom));
        bx = bw[0:16];
        send_frames("ovf", bw, bx, 8, 1, 1, 1, 8'h00);

        wr_reg(3'd2, 8'h00);
        bw = {8'hC3, 8'h3C, 8'h99};
        bx = {8'hC3, 8'h3C};
        send_frames("dep1", bw, bx, 8, 1, 1, 1, 8'h00);

        wr_reg(3'd2, 8'h01);
        wr_reg(3'd1, 8'h02);
        chk("ier_int", intr, 1'b1);
        rd_chk("ier_rb", 3'd1, 8'h02);
        rd_chk("iir_c2", 3'd2, 8'hC2);
        chk("iir_clr_int", intr, 1'b0);
        rd_chk("iir_c1", 3'd2, 8'hC1);
        wr_reg(3'd0, 8'h11);
        cycles(5);
        wr_reg(3'd0, 8'h22);
        chk("thr_clr_int", intr, 1'b0);
        got = 0;
        for (int k = 0; k < 1000 && got == 0; k++) begin
            cycles(1);
            if (intr) got = 1;
        end
        chk("drain_int", got, 1);
        cycles(300);

        set_cfg(8'h04, 8'h01);
        bw = {8'h1F};
        send_frames("w5s2", bw, bw, 5, 2, 1, 1, -1);
        wr_reg(3'd3, 8'h43);
        chk("brk_on", sout, 1'b0);
        wr_reg(3'd3, 8'h03);
        chk("brk_off", sout, 1'b1);

        wr_reg(3'd7, 8'h5A);
        rd_chk("scr_rb", 3'd7, 8'h5A);
        wr_reg(3'd4, 8'h13);
        rd_chk("mcr_rb", 3'd4, 8'h13);
        rd_chk("msr_rd", 3'd6, 8'h00);
        wr_reg(3'd5, 8'hFF);
        rd_chk("lsr_ro", 3'd5, 8'h60);
        rd_chk("rbr_rd", 3'd0, 8'h00);
        wr_reg(3'd1, 8'hFF);
        rd_chk("ier_mask", 3'd1, 8'h02);

        set_cfg(8'h03, 8'h00);
        wr_reg(3'd0, 8'hA5);
        cycles(50);
        chk("div0_hold", sout, 1'b0);
        rd_chk("div0_lsr", 3'd5, 8'h20);
        rst = 1'b1;
        cycles(1);
        chk("mid_rst_sout", sout, 1'b1);
        rst = 1'b0;
        chk("mid_rst_int", intr, 1'b0);
        rd_chk("mid_rst_lsr", 3'd5, 8'h60);
        rd_chk("mid_rst_lcr", 3'd3, 8'h00);
        wr_reg(3'd3, 8'h80);
        rd_chk("mid_rst_dll", 3'd0, 8'h00);
        rd_chk("mid_rst_dlm", 3'd1, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
